serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder stage per clock, LSB first,
// with a three-state controller (IDLE -> RUN -> DONE).
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_c;
  logic             w_last;

  // Single full-adder stage shared across all bit positions
  assign w_s    = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_c    = (r_opa[0] & r_opb[0]) | (r_carry & (r_opa[0] ^ r_opb[0]));
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Subtraction as a + ~b + 1: invert b and force the carry-in
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_res   <= '0;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_res   <= {w_s, r_res[WIDTH-1:1]};
          r_carry <= w_c;
          r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
          r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
          if (w_last) begin
            r_sum  <= {w_s, r_res[WIDTH-1:1]};
            r_cout <= w_c;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
